img_pixel_streamer: RTL

- Frame source that feeds the line-buffer shift register.
- Holds one IMG_WIDTH x IMG_HEIGHT frame in an internal register array, loaded through a simple write port.
- On start, emits the frame in raster order as a serial pixel stream (write_en / serial_img_in), one pixel per clock, with a stall input.
- Sits between the host-side load logic and the convolution window generator.

---
 rtl/img_pixel_streamer.sv | 119 +++++++++++
 1 files changed

// File: rtl/img_pixel_streamer.sv
// img_pixel_streamer: frame buffer that streams its contents in raster order,
// optionally with a zero border (define IMG_PIXEL_STREAMER_PAD_EN).
module img_pixel_streamer #(
    parameter int BITS        = 9,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   load_en,
    input  logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] load_addr,
    input  logic [BITS-1:0]                        load_data,
    input  logic                                   start,
    input  logic                                   stall,
    output logic                                   write_en,
    output logic [BITS-1:0]                        serial_img_in,
    output logic                                   busy,
    output logic                                   done
);
`ifdef IMG_PIXEL_STREAMER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW = $clog2(N);
    localparam int P  = PAD ? (KERNEL_SIZE - 1) / 2 : 0;
    localparam int PW = IMG_WIDTH + 2 * P;
    localparam int PH = IMG_HEIGHT + 2 * P;
    localparam int CW = PW > 1 ? $clog2(PW) : 1;
    localparam int RW = PH > 1 ? $clog2(PH) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic            r_fin;
    logic [BITS-1:0] r_mem [0:N-1];
    logic [AW-1:0]   w_idx;
    logic [BITS-1:0] w_pix;
    logic            w_last;
    logic            w_col_wrap;

    assign w_col_wrap = r_col == CW'(PW - 1);
    assign w_last     = w_col_wrap && r_row == RW'(PH - 1);

`ifdef IMG_PIXEL_STREAMER_PAD_EN
    logic w_border;
    // Border positions read as zero; interior positions are shifted back by P.
    always_comb begin
        w_border = r_row < RW'(P) || r_row >= RW'(P + IMG_HEIGHT) ||
                   r_col < CW'(P) || r_col >= CW'(P + IMG_WIDTH);
        w_idx    = AW'(r_row - RW'(P)) * AW'(IMG_WIDTH) + AW'(r_col - CW'(P));
        w_pix    = w_border ? '0 : r_mem[w_idx];
    end
`else
    // Raster address of the current pixel.
    always_comb begin
        w_idx = AW'(r_row) * AW'(IMG_WIDTH) + AW'(r_col);
        w_pix = r_mem[w_idx];
    end
`endif

    // Frame memory: writable only while idle, survives reset.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && load_en && {1'b0, load_addr} < (AW+1)'(N))
            r_mem[load_addr] <= load_data;
    end

    // Stream control: one pixel per unstalled edge, then a one-cycle done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_col         <= '0;
            r_row         <= '0;
            r_fin         <= 1'b0;
            write_en      <= 1'b0;
            serial_img_in <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state <= STREAM;
                        busy    <= 1'b1;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_fin   <= 1'b0;
                    end
                end
                STREAM: begin
                    if (r_fin) begin
                        r_state  <= DONE;
                        write_en <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else if (stall) begin
                        write_en <= 1'b0;
                    end else begin
                        write_en      <= 1'b1;
                        serial_img_in <= w_pix;
                        r_fin         <= w_last;
                        r_col         <= w_col_wrap ? '0 : r_col + 1'b1;
                        r_row         <= w_col_wrap ? r_row + 1'b1 : r_row;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
